// File: rtl/minisys_pkg.sv
// minisys_pkg: shared types and constants for the minisys blocks.
//   div_state_e : divider FSM states (IDLE, CALC, FIX, DONE)
//   DIV_ITER    : number of restoring-division steps
//   DIV_DZ_QUO  : quotient returned for a zero divisor
//   mag32/neg32 : two's-complement magnitude / conditional negate helpers
package minisys_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    localparam int unsigned DIV_ITER   = 32;
    localparam logic [31:0] DIV_DZ_QUO = 32'hFFFFFFFF;

    // 32'h80000000 maps to itself, which reads correctly as unsigned 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] x, input logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/addsub_32.sv
// addsub_32: 32-bit adder/subtractor.
//   a, b     : operands
//   sub_ctrl : 1 = a - b, 0 = a + b
//   y        : result (mod 2^32)
//   cf       : carry out when adding, borrow out when subtracting
module addsub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub_ctrl,
    output logic [31:0] y,
    output logic        cf
);

    logic [32:0] sum;

    assign sum = {1'b0, a} + {1'b0, b ^ {32{sub_ctrl}}} + {32'd0, sub_ctrl};
    assign y   = sum[31:0];
    // For subtraction the raw carry is the inverse of the borrow.
    assign cf  = sum[32] ^ sub_ctrl;

endmodule

// File: rtl/div_32.sv
// div_32: multi-cycle 32-bit restoring divider (DIV / DIVU).
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request a division (sampled in IDLE only)
//   a, b       : dividend, divisor
//   sign_ctrl  : 1 = signed, 0 = unsigned
//   busy       : operation in progress (CALC, FIX, DONE)
//   done       : one-cycle pulse, results valid from this cycle
//   quo, rem   : quotient (LO) and remainder (HI), held until next start
//   dz         : divisor was zero
// Build option: define DIV_SIGNED_EN to honour sign_ctrl; otherwise all
// operations are unsigned and FIX passes values through unchanged.
module div_32
    import minisys_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign_ctrl,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        dz
);

    localparam logic [4:0] LastIter = 5'(DIV_ITER - 1);

    logic signed_mode;
`ifdef DIV_SIGNED_EN
    assign signed_mode = sign_ctrl;
`else
    logic unused_sign_ctrl;
    assign unused_sign_ctrl = sign_ctrl;
    assign signed_mode      = 1'b0;
`endif

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] pr_q, pr_d;      // partial remainder
    logic [31:0] qd_q, qd_d;      // dividend shifting out, quotient shifting in
    logic [31:0] dvs_q, dvs_d;    // divisor magnitude
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic        dz_q, dz_d;

    logic [31:0] step_rem;
    logic [31:0] step_diff;
    logic        step_cf;
    logic        step_take;

    // The shifted remainder is really 33 bits; pr_q[31] is its top bit.
    assign step_rem = {pr_q[30:0], qd_q[31]};

    addsub_32 u_addsub (
        .a        (step_rem),
        .b        (dvs_q),
        .sub_ctrl (1'b1),
        .y        (step_diff),
        .cf       (step_cf)
    );

    // With the hidden top bit set the value exceeds any divisor, so the
    // subtract always succeeds and its 32-bit difference is exact.
    assign step_take = pr_q[31] | ~step_cf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (b == 32'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LastIter) begin
                    state_d = FIX;
                end
            end
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        qd_d      = qd_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = 5'd0;
                    pr_d      = 32'd0;
                    qd_d      = mag32(a, signed_mode);
                    dvs_d     = mag32(b, signed_mode);
                    quo_neg_d = signed_mode & (a[31] ^ b[31]);
                    rem_neg_d = signed_mode & a[31];
                    if (b == 32'd0) begin
                        dz_d  = 1'b1;
                        quo_d = DIV_DZ_QUO;
                        rem_d = a;
                    end else begin
                        dz_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                pr_d  = step_take ? step_diff : step_rem;
                qd_d  = {qd_q[30:0], step_take};
            end
            FIX: begin
                quo_d = neg32(qd_q, quo_neg_q);
                rem_d = neg32(pr_q, rem_neg_q);
            end
            DONE: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 5'd0;
            pr_q      <= 32'd0;
            qd_q      <= 32'd0;
            dvs_q     <= 32'd0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dz_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            qd_q      <= qd_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;
    assign dz  = dz_q;

endmodule

// File: doc/div_32.md
DIV_32 -- requirements
Module: div_32

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 a  input  32  dividend.
REQ-006 b  input  32  divisor.
REQ-007 sign_ctrl  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-008 busy  output  1  high from the edge after start is accepted until done falls.
REQ-009 done  output  1  one-cycle pulse; quo, rem and dz are valid from this cycle.
REQ-010 quo  output  32  quotient, the LO write value.
REQ-011 rem  output  32  remainder, the HI write value.
REQ-012 dz  output  1  divisor was zero.

Function
REQ-013 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-014 In IDLE with start=1, the block SHALL latch a, b and sign_ctrl, clear the 5-bit iteration counter, and go to CALC; if b==0 it SHALL instead go directly to DONE.
REQ-015 CALC SHALL perform one restoring-division step per cycle on operand magnitudes: shift the partial remainder left and subtract the divisor magnitude via addsub_32 (sub_ctrl=1); on no-borrow (cf=0) keep the difference and shift in quotient bit 1, else restore and shift in 0.
REQ-016 CALC SHALL last exactly 32 cycles (counter 0..31), then go to FIX.
REQ-017 FIX SHALL negate the quotient when the signed-mode operand signs differ and negate the remainder when the signed-mode dividend is negative (truncation toward zero), then go to DONE.
REQ-018 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-019 Latency SHALL be exactly 34 rising edges from the edge accepting start to the cycle with done=1; for a zero divisor it SHALL be 1 edge.
REQ-020 quo, rem and dz SHALL hold their values after done until the next accepted start.
REQ-021 start SHALL be ignored while busy=1; a start in the DONE cycle SHALL be ignored.
REQ-022 Divide by zero SHALL give dz=1, quo=32'hFFFFFFFF, rem=a.
REQ-023 A signed 32'h80000000 / 32'hFFFFFFFF SHALL give quo=32'h80000000, rem=0, dz=0.
REQ-024 The magnitude of 32'h80000000 SHALL be handled as unsigned 2^31 without error.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, and busy, done, dz, quo, rem and the counter to 0.
REQ-026 A reset during CALC or FIX SHALL abort the operation with no done pulse; a start on the first edge after rst falls SHALL be accepted normally.

Configuration
REQ-027 Macro DIV_SIGNED_EN: when defined, sign_ctrl behaves as in REQ-015 to REQ-017, REQ-023 and REQ-024.
REQ-028 Without DIV_SIGNED_EN, sign_ctrl SHALL be ignored, all operations SHALL be unsigned, FIX SHALL pass values unchanged, and the latency SHALL stay 34 edges.

Structure
REQ-029 The shared package minisys_pkg SHALL hold the div-state typedef (IDLE/CALC/FIX/DONE) and the constants DIV_ITER=32 and DIV_DZ_QUO=32'hFFFFFFFF.
REQ-030 The block SHALL instantiate exactly one existing addsub_32 for the per-step subtract; no other sub-module is needed.

Verification
REQ-031 Unsigned 100/7: a=100, b=7, sign_ctrl=0 -> done at edge 34, quo=14, rem=2, dz=0.
REQ-032 Signed -7/2: a=32'hFFFFFFF9, b=2, sign_ctrl=1 -> quo=32'hFFFFFFFD, rem=32'hFFFFFFFF.
REQ-033 Overflow boundary: a=32'h80000000, b=32'hFFFFFFFF -> signed: quo=32'h80000000, rem=0; unsigned: quo=0, rem=32'h80000000.
REQ-034 Zero divisor: a=32'h12345678, b=0 -> done at edge 1, dz=1, quo=32'hFFFFFFFF, rem=32'h12345678.
REQ-035 Start while busy: second start with new operands at edge 10 -> ignored; first result returned at edge 34.
REQ-036 Reset mid-operation: rst pulse at edge 15 -> outputs go to 0, no done pulse; a new start after reset gives the correct result.
